// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

    // Fetch control states; encoding 3 is unused and recovers to BOOT.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    // Default PC after reset (truncated to the instance address width).
    localparam logic [63:0] DEFAULT_RESET_ADDR = 64'h0;

    // Redirect channel indices; a lower index wins.
    localparam int REDIR_TRAP    = 0;
    localparam int REDIR_MISPRED = 1;
    localparam int REDIR_JUMP    = 2;
    localparam int REDIR_DEBUG   = 3;

    // Width of a channel index, never less than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect selector: the lowest-numbered valid channel wins.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter  int NUM_REDIRECT = 4,
    parameter  int ADDR_WIDTH   = 64,
    localparam int ID_WIDTH     = id_width(NUM_REDIRECT)
) (
    input  logic [NUM_REDIRECT-1:0]            valid,
    input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] target,
    output logic                               any,
    output logic [ID_WIDTH-1:0]                index,
    output logic [ADDR_WIDTH-1:0]              sel_target
);

    // Scan from the lowest-priority channel upward so the last hit is the winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; otherwise a path that skips it infers a latch.
        any        = |valid;
        index      = '0;
        sel_target = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (valid[i]) begin
                index      = ID_WIDTH'(i);
                sel_target = target[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: boot hold-off, prioritised
// redirects that override stall, fetch valid/ready handshake, debug halt and
// resume, redirect-target alignment flag and an accepted-fetch counter.
module pc_gen
    import pc_pkg::*;
#(
    parameter  int                    ADDR_WIDTH   = 64,
    parameter  logic [ADDR_WIDTH-1:0] RESET_ADDR   = ADDR_WIDTH'(DEFAULT_RESET_ADDR),
    parameter  int                    INST_BYTES   = 4,
    parameter  int                    NUM_REDIRECT = 4,
    parameter  int                    BOOT_DELAY   = 2,
    parameter  int                    CNT_WIDTH    = 32,
    localparam int                    ID_WIDTH     = id_width(NUM_REDIRECT)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic [NUM_REDIRECT-1:0]            redirect_valid,
    input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_target,
    input  logic                               halt_req,
    input  logic                               resume_req,
    input  logic                               fetch_ready,
    output logic                               fetch_valid,
    output logic [ADDR_WIDTH-1:0]              pc_reg,
    output logic [ADDR_WIDTH-1:0]              pc_seq,
    output logic                               redirect_taken,
    output logic [ID_WIDTH-1:0]                redirect_id,
    output logic                               misaligned,
    output logic [1:0]                         state_o,
    output logic [CNT_WIDTH-1:0]               fetch_count
);

    // Low PC bits that must be zero for an instruction-aligned address.
    localparam int ALIGN_BITS = $clog2(INST_BYTES);
    // Boot counter wide enough to hold BOOT_DELAY itself.
    localparam int BOOT_W     = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

    pc_state_e             state_q, state_d;
    logic [BOOT_W-1:0]     boot_cnt_q, boot_cnt_d;
    logic                  halt_pend_q, halt_pend_d;

    logic                  fire;
    logic                  redir_any;
    logic [ID_WIDTH-1:0]   redir_idx;
    logic [ADDR_WIDTH-1:0] redir_target;
    logic [ADDR_WIDTH-1:0] aligned_target;
    logic                  low_bits_set;
    logic [ADDR_WIDTH-1:0] pc_next;

    // ------------------------------------------------------------------
    // Handshake and sequential address
    // ------------------------------------------------------------------
    assign fetch_valid = (state_q == RUN);
    assign fire        = fetch_valid & fetch_ready & ~stall;
    // Natural modulo-2^ADDR_WIDTH wrap; no overflow flag is wanted.
    assign pc_seq      = pc_reg + ADDR_WIDTH'(INST_BYTES);
    assign state_o     = state_q;

    // ------------------------------------------------------------------
    // Redirect selection and alignment
    // ------------------------------------------------------------------
    pc_redirect_arb #(
        .NUM_REDIRECT (NUM_REDIRECT),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_arb (
        .valid      (redirect_valid),
        .target     (redirect_target),
        .any        (redir_any),
        .index      (redir_idx),
        .sel_target (redir_target)
    );

    // Targets are forced onto an instruction boundary; dropped bits are flagged.
    assign aligned_target = {redir_target[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    assign low_bits_set   = |redir_target[ALIGN_BITS-1:0];

    // Next PC: redirect beats sequential advance, which beats hold. Redirects
    // apply in every state so a halted debugger can still write the PC.
    always_comb begin
        pc_next = pc_reg;
        if (redir_any) begin
            pc_next = aligned_target;
        end else if (fire) begin
            pc_next = pc_seq;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // Next-state logic: boot hold-off, halt/resume, recovery from encoding 3.
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == '0) begin
                    state_d     = (halt_pend_q | halt_req) ? HALTED : RUN;
                    halt_pend_d = 1'b0;
                end else begin
                    boot_cnt_d = boot_cnt_q - BOOT_W'(1);
                    if (halt_req) begin
                        halt_pend_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                // A simultaneous halt request keeps the core parked.
                if (resume_req & ~halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d     = BOOT;
                boot_cnt_d  = BOOT_W'(BOOT_DELAY);
                halt_pend_d = 1'b0;
            end
        endcase
    end

    // State register with immediate asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all clocked state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= BOOT;
            boot_cnt_q  <= BOOT_W'(BOOT_DELAY);
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // PC, redirect status and fetch counter
    // ------------------------------------------------------------------
    // Datapath registers; status pulses clear on any edge without a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg         <= RESET_ADDR;
            redirect_taken <= 1'b0;
            redirect_id    <= '0;
            misaligned     <= 1'b0;
            fetch_count    <= '0;
        end else begin
            pc_reg         <= pc_next;
            redirect_taken <= redir_any;
            misaligned     <= redir_any & low_bits_set;
            // The id keeps naming the last winner between redirects.
            if (redir_any) begin
                redirect_id <= redir_idx;
            end
            // A fire is still counted when a redirect overrides its PC advance.
            if (fire) begin
                fetch_count <= fetch_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: a 64-bit instance for boot, fetch,
// stall, redirect, halt and reset behaviour, and a 16-bit instance for wrap.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int AW = 64;
    localparam int NR = 4;
    localparam int AW16 = 16;
    localparam int NR16 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance stimulus/observation
    logic              reset, stall, halt_req, resume_req, fetch_ready;
    logic [NR-1:0]     rv;
    logic [NR*AW-1:0]  rt;
    logic              fetch_valid, redirect_taken, misaligned;
    logic [AW-1:0]     pc_reg, pc_seq;
    logic [1:0]        redirect_id, state_o;
    logic [31:0]       fetch_count;

    // 16-bit instance stimulus/observation
    logic                  reset16, stall16, halt16, resume16, ready16;
    logic [NR16-1:0]       rv16;
    logic [NR16*AW16-1:0]  rt16;
    logic                  fv16, taken16, mis16;
    logic [AW16-1:0]       pc16, seq16;
    logic [0:0]            id16;
    logic [1:0]            st16;
    logic [7:0]            cnt16;

    int n_cmp = 0;
    int n_err = 0;

    pc_gen #(
        .ADDR_WIDTH(AW), .RESET_ADDR(64'h1000), .INST_BYTES(4),
        .NUM_REDIRECT(NR), .BOOT_DELAY(2), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(rv), .redirect_target(rt),
        .halt_req(halt_req), .resume_req(resume_req), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc_reg(pc_reg), .pc_seq(pc_seq),
        .redirect_taken(redirect_taken), .redirect_id(redirect_id),
        .misaligned(misaligned), .state_o(state_o), .fetch_count(fetch_count)
    );

    pc_gen #(
        .ADDR_WIDTH(AW16), .RESET_ADDR(16'hFFF0), .INST_BYTES(4),
        .NUM_REDIRECT(NR16), .BOOT_DELAY(0), .CNT_WIDTH(8)
    ) dut16 (
        .clk(clk), .reset(reset16), .stall(stall16),
        .redirect_valid(rv16), .redirect_target(rt16),
        .halt_req(halt16), .resume_req(resume16), .fetch_ready(ready16),
        .fetch_valid(fv16), .pc_reg(pc16), .pc_seq(seq16),
        .redirect_taken(taken16), .redirect_id(id16),
        .misaligned(mis16), .state_o(st16), .fetch_count(cnt16)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
        fetch_ready = 1'b1; rv = '0; rt = '0;
        reset16 = 1'b1; stall16 = 1'b0; halt16 = 1'b0; resume16 = 1'b0;
        ready16 = 1'b0; rv16 = '0; rt16 = '0;

        tick(); tick();

        // Reset state
        check("rst_pc",       pc_reg, 64'h1000);
        check("rst_seq",      pc_seq, 64'h1004);
        check("rst_state",    state_o, 64'(BOOT));
        check("rst_valid",    fetch_valid, 0);
        check("rst_count",    fetch_count, 0);
        check("rst_taken",    redirect_taken, 0);
        check("rst_id",       redirect_id, 0);
        check("rst_mis",      misaligned, 0);

        // Boot hold-off: fetch_valid rises on the third edge after release
        reset = 1'b0;
        tick();
        check("boot_e1_valid", fetch_valid, 0);
        tick();
        check("boot_e2_valid", fetch_valid, 0);
        check("boot_e2_state", state_o, 64'(BOOT));
        tick();
        check("boot_e3_valid", fetch_valid, 1);
        check("boot_e3_state", state_o, 64'(RUN));
        check("boot_e3_pc",    pc_reg, 64'h1000);

        // Sequential fetch
        tick();
        check("seq1_pc", pc_reg, 64'h1004);
        tick();
        check("seq2_pc", pc_reg, 64'h1008);
        tick();
        check("seq3_pc",    pc_reg, 64'h100C);
        check("seq3_count", fetch_count, 3);

        // Trap redirect to 0x2000; the concurrent fire is still counted
        rv[REDIR_TRAP] = 1'b1; rt[REDIR_TRAP*AW +: AW] = 64'h2000;
        tick();
        check("trap_pc",    pc_reg, 64'h2000);
        check("trap_taken", redirect_taken, 1);
        check("trap_id",    redirect_id, REDIR_TRAP);
        check("trap_count", fetch_count, 4);
        rv = '0; rt = '0;

        // Stall for two cycles
        stall = 1'b1;
        tick();
        check("stall1_pc",    pc_reg, 64'h2000);
        check("stall1_taken", redirect_taken, 0);
        tick();
        check("stall2_pc",    pc_reg, 64'h2000);
        check("stall2_count", fetch_count, 4);

        // Backpressure
        stall = 1'b0; fetch_ready = 1'b0;
        tick();
        check("bp_pc",    pc_reg, 64'h2000);
        check("bp_count", fetch_count, 4);

        // Channels 1 and 3 together under stall: channel 1 wins
        fetch_ready = 1'b1; stall = 1'b1;
        rv[REDIR_MISPRED] = 1'b1; rt[REDIR_MISPRED*AW +: AW] = 64'h8000;
        rv[REDIR_DEBUG]   = 1'b1; rt[REDIR_DEBUG*AW +: AW]   = 64'h9000;
        tick();
        check("prio_pc",    pc_reg, 64'h8000);
        check("prio_id",    redirect_id, REDIR_MISPRED);
        check("prio_taken", redirect_taken, 1);
        check("prio_count", fetch_count, 4);
        rv = '0; rt = '0;
        tick();
        check("prio_pulse_end", redirect_taken, 0);
        check("prio_id_hold",   redirect_id, REDIR_MISPRED);
        check("prio_pc_hold",   pc_reg, 64'h8000);

        // Misaligned jump target
        stall = 1'b0;
        rv[REDIR_JUMP] = 1'b1; rt[REDIR_JUMP*AW +: AW] = 64'h4006;
        tick();
        check("mis_pc",    pc_reg, 64'h4004);
        check("mis_flag",  misaligned, 1);
        check("mis_id",    redirect_id, REDIR_JUMP);
        check("mis_count", fetch_count, 5);
        rv = '0; rt = '0;
        tick();
        check("mis_clear", misaligned, 0);
        check("mis_next",  pc_reg, 64'h4008);

        // Halt in RUN; the fire in the same cycle still advances
        halt_req = 1'b1;
        tick();
        check("halt_state", state_o, 64'(HALTED));
        check("halt_valid", fetch_valid, 0);
        check("halt_pc",    pc_reg, 64'h400C);
        check("halt_count", fetch_count, 7);
        halt_req = 1'b0;
        tick();
        check("halted_hold", pc_reg, 64'h400C);

        // Debugger PC write while halted
        rv[REDIR_DEBUG] = 1'b1; rt[REDIR_DEBUG*AW +: AW] = 64'h100;
        tick();
        check("dbg_pc",    pc_reg, 64'h100);
        check("dbg_id",    redirect_id, REDIR_DEBUG);
        check("dbg_state", state_o, 64'(HALTED));
        rv = '0; rt = '0;

        // Halt and resume together: stay halted
        halt_req = 1'b1; resume_req = 1'b1;
        tick();
        check("both_state", state_o, 64'(HALTED));

        // Resume alone
        halt_req = 1'b0;
        tick();
        check("resume_state", state_o, 64'(RUN));
        check("resume_valid", fetch_valid, 1);
        check("resume_pc",    pc_reg, 64'h100);
        resume_req = 1'b0;
        tick();
        check("resume_fetch", pc_reg, 64'h104);
        check("resume_count", fetch_count, 8);

        // Asynchronous reset mid-cycle, then halt seen during BOOT
        #3;
        reset = 1'b1;
        #1;
        check("arst_pc",    pc_reg, 64'h1000);
        check("arst_state", state_o, 64'(BOOT));
        check("arst_count", fetch_count, 0);
        tick();
        reset = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check("pend_boot", state_o, 64'(BOOT));
        tick();
        check("pend_halt", state_o, 64'(HALTED));

        // 16-bit instance: zero boot delay, misaligned target, wrap
        reset16 = 1'b0;
        tick();
        check("w_state", st16, 64'(RUN));
        check("w_pc",    pc16, 64'hFFF0);
        ready16 = 1'b1;
        rv16[1] = 1'b1; rt16[AW16 +: AW16] = 16'hFFFE;
        tick();
        check("w_redir_pc", pc16, 64'hFFFC);
        check("w_redir_id", id16, 1);
        check("w_mis",      mis16, 1);
        check("w_seq",      seq16, 64'h0000);
        rv16 = '0; rt16 = '0;
        tick();
        check("w_wrap_pc",  pc16, 64'h0000);
        check("w_wrap_cnt", cnt16, 2);
        #3;
        reset16 = 1'b1;
        #1;
        check("w_arst_pc",    pc16, 64'hFFF0);
        check("w_arst_state", st16, 64'(BOOT));
        check("w_arst_valid", fv16, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage, and the next generation of the plain stall/hold PC register.
- Adds a boot hold-off after reset.
- Adds N prioritised redirect channels (trap, mispredict, jump, debug) that override stall.
- Adds a fetch valid/ready handshake, debug halt/resume, redirect-target alignment checking and a fetch counter.
- Sits between the redirect sources (EX/MEM/CSR/debug) and the instruction-fetch request port.

Parameters:
ADDR_WIDTH, 64, PC width in bits
RESET_ADDR, 0, PC value loaded on reset (ADDR_WIDTH bits)
INST_BYTES, 4, sequential increment; power of two, 2 or 4
NUM_REDIRECT, 4, redirect channels; index 0 = highest priority
BOOT_DELAY, 2, cycles held in BOOT after reset release (0 allowed)
CNT_WIDTH, 32, fetch counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  pipeline stall; blocks sequential advance only
redirect_valid  in  NUM_REDIRECT  per-channel redirect request
redirect_target  in  NUM_REDIRECT*ADDR_WIDTH  packed targets; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
halt_req  in  1  debug halt request (level)
resume_req  in  1  debug resume request (level)
fetch_ready  in  1  fetch port accepts pc_reg
fetch_valid  out  1  pc_reg is a valid fetch request
pc_reg  out  ADDR_WIDTH  current PC
pc_seq  out  ADDR_WIDTH  combinational pc_reg + INST_BYTES
redirect_taken  out  1  registered pulse: a redirect was applied last edge
redirect_id  out  $clog2(NUM_REDIRECT) (min 1)  winning channel of last redirect
misaligned  out  1  registered pulse: applied target had nonzero low bits
state_o  out  2  BOOT=0, RUN=1, HALTED=2
fetch_count  out  CNT_WIDTH  accepted fetches

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - pc_reg=RESET_ADDR, state=BOOT, boot_cnt=BOOT_DELAY.
  - halt_pend=0, fetch_count=0, redirect_taken=0, redirect_id=0, misaligned=0.
- fetch_valid = (state==RUN). It is combinational from state only.
- fire = fetch_valid & fetch_ready & ~stall.
- PC update priority at each edge, any state:
  1. Any redirect_valid set: pc_reg <= target of the lowest set index, with the low log2(INST_BYTES) bits forced to 0.
     - redirect_taken<=1 and redirect_id<=index.
     - misaligned<=1 if the dropped bits were nonzero.
     - Overrides stall and fetch_ready.
  2. Else if fire: pc_reg <= pc_reg + INST_BYTES, modulo 2^ADDR_WIDTH (wrap to 0, no flag).
  3. Else: hold.
  - redirect_taken and misaligned return to 0 on any edge with no redirect.
- fetch_count increments on fire, including a fire in the same cycle as a redirect; it wraps silently.
- State machine:
  - BOOT:
    - boot_cnt==0 → next state is HALTED if halt_pend or halt_req, else RUN.
    - Otherwise boot_cnt decrements.
    - halt_req seen in BOOT sets sticky halt_pend.
    - BOOT_DELAY=0 leaves BOOT on the first edge after reset release.
  - RUN: halt_req → HALTED at the next edge. A fire in that same cycle still advances the PC.
  - HALTED:
    - fetch_valid=0 and the PC holds, except that redirects still load it (debugger PC write).
    - resume_req & ~halt_req → RUN.
    - halt_req and resume_req together: stay HALTED.
  - halt_pend clears on leaving BOOT.
- Latency:
  - A redirect is visible on pc_reg one cycle after assertion.
  - fetch_valid rises BOOT_DELAY+1 edges after reset release.
- Unused state encoding 3 → BOOT on the next edge.

Decomposition:
- Package pc_pkg holds:
  - state enum pc_state_e (BOOT, RUN, HALTED).
  - Default RESET_ADDR.
  - Channel index constants REDIR_TRAP=0, REDIR_MISPRED=1, REDIR_JUMP=2, REDIR_DEBUG=3.
- One sub-module, pc_redirect_arb: combinational fixed-priority select returning any/index/target. It is parametrised on NUM_REDIRECT and ADDR_WIDTH.

Test Plan:
- Boot and sequential fetch (BOOT_DELAY=2, RESET_ADDR=0x1000, fetch_ready=1):
  - fetch_valid rises on the 3rd edge after release.
  - pc_reg steps 0x1000, 0x1004, 0x1008; fetch_count=3 after three fires.
- Stall and backpressure:
  - stall=1 for 2 cycles at pc=0x2000 → pc holds 0x2000, fetch_count unchanged.
  - fetch_ready=0 → same hold.
- Redirect priority:
  - Channels 1 (0x8000) and 3 (0x9000) asserted together while stall=1 → pc_reg=0x8000, redirect_id=1, redirect_taken pulses one cycle.
- Misaligned target:
  - Channel 2 with target 0x4006, INST_BYTES=4 → pc_reg=0x4004, misaligned=1 for one cycle.
- Halt and resume:
  - halt_req in RUN → state HALTED, fetch_valid=0.
  - Debug redirect 0x100 → pc_reg=0x100.
  - halt_req and resume_req together → stays HALTED.
  - resume_req alone → RUN, fetch at 0x100.
- Wrap and async reset (ADDR_WIDTH=16):
  - pc=0xFFFC with fire → 0x0000.
  - Assert reset between edges → pc_reg=RESET_ADDR and state BOOT immediately, without waiting for an edge.
